// File: rtl/glip_seq_tester.sv
// glip_seq_tester
//   Sequence generator/checker that sits on the GLIP FIFO interface in place
//   of the plain data loopback.
//
//   Input side (checker):
//     The host sends an incrementing word sequence on in_data.
//     The first word accepted after a sync point sets the expected sequence.
//     Every later word is compared against it. A mismatch raises the sticky
//     error flag, bumps a saturating err_count and resynchronises to the
//     word that was received.
//
//   Output side (generator):
//     Produces an incrementing word sequence on out_data with valid/ready
//     handshaking. It runs independently of the input side.
//
// Ports
//   clk        single clock for all logic
//   rst        asynchronous active-high reset
//   in_data    word from the host (fifo_in_data)
//   in_valid   in_data valid
//   in_ready   block accepts in_data (registered, high one edge after reset)
//   out_data   generated word to the host (fifo_out_data)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   gen_en     generator enable
//   chk_en     checker enable; low forces the checker back to SYNC
//   clr        synchronous clear of the status registers
//   error      sticky mismatch flag
//   err_count  saturating mismatch count
//   rx_count   accepted input words (wraps at 2^32)
//   tx_count   completed output transfers (wraps at 2^32)
//
// Checker states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SYNC     | waiting for a word to seed the expected sequence
//   CHECK    | comparing every accepted word against the expected value

module glip_seq_tester #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             gen_en,
  input  logic             chk_en,
  input  logic             clr,
  output logic             error,
  output logic [15:0]      err_count,
  output logic [31:0]      rx_count,
  output logic [31:0]      tx_count
);

  localparam logic [0:0]       ST_SYNC  = 1'b0;
  localparam logic [0:0]       ST_CHECK = 1'b1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             r_in_ready;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_expected;
  logic             r_error;
  logic [15:0]      r_err_count;
  logic [31:0]      r_rx_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [31:0]      r_tx_count;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_in_data_inc;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_expected_nxt;
  logic             w_mismatch;

  assign w_in_xfer     = in_valid & r_in_ready;
  assign w_out_xfer    = r_out_valid & out_ready;
  assign w_in_data_inc = in_data + ONE;

  // ---------------------------------------------------------------------
  // Checker FSM
  //
  // clr and chk_en=0 both pull the FSM back to SYNC. Any input transfer in
  // that same cycle is not compared. Arithmetic is modulo 2^WIDTH, so an
  // all-ones word followed by zero counts as in sequence.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_mismatch     = 1'b0;
    if (clr || !chk_en) begin
      w_state_nxt = ST_SYNC;
    end else if (w_in_xfer) begin
      case (r_state)
        ST_SYNC: begin
          w_expected_nxt = w_in_data_inc;
          w_state_nxt    = ST_CHECK;
        end
        ST_CHECK: begin
          if (in_data == r_expected) begin
            w_expected_nxt = r_expected + ONE;
          end else begin
            w_mismatch     = 1'b1;
            w_expected_nxt = w_in_data_inc;
          end
        end
        default: begin
          w_state_nxt = ST_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_state    <= ST_SYNC;
      r_expected <= '0;
    end else begin
      r_in_ready <= 1'b1;
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Input-side status.
  // An input transfer that coincides with clr is dropped entirely.
  // w_mismatch is already suppressed under clr by the FSM logic above.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error     <= 1'b0;
      r_err_count <= '0;
      r_rx_count  <= '0;
    end else if (clr) begin
      r_error     <= 1'b0;
      r_err_count <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_in_xfer) begin
        r_rx_count <= r_rx_count + 32'd1;
      end
      if (w_mismatch) begin
        r_error <= 1'b1;
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Generator.
  // A presented word stays put until it is taken, even if gen_en drops.
  // clr only rewinds out_data when nothing is pending, so a word the
  // downstream may already be looking at is never altered. A transfer
  // that coincides with clr still advances the sequence but is not
  // counted in tx_count.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_tx_count  <= '0;
    end else begin
      r_out_valid <= gen_en | (r_out_valid & ~out_ready);
      if (w_out_xfer) begin
        r_out_data <= r_out_data + ONE;
      end else if (clr && !r_out_valid) begin
        r_out_data <= '0;
      end
      if (clr) begin
        r_tx_count <= '0;
      end else if (w_out_xfer) begin
        r_tx_count <= r_tx_count + 32'd1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign error     = r_error;
  assign err_count = r_err_count;
  assign rx_count  = r_rx_count;
  assign tx_count  = r_tx_count;

endmodule
